// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry {pc, inst} FIFO between IF and ID with flush and bubble output.
// Optional statistics counters are enabled by defining FETCHBUF_STATS_EN.
module fetch_buf #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
`ifdef FETCHBUF_STATS_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_drop_cnt,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic              enq_s;
    logic              deq_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign enq_s   = if_valid && !full_s;
    assign deq_s   = !empty_s && !id_stall;

    // Handshake and head-entry outputs; an empty buffer presents an all-zero bubble.
    always_comb begin
        if_ready = !full_s;
        id_valid = !empty_s;
        count    = count_r;
        id_pc    = {ADDR_W{1'b0}};
        id_inst  = {INST_W{1'b0}};
        if (!empty_s) begin
            id_pc   = pc_mem_r[rd_ptr_r];
            id_inst = inst_mem_r[rd_ptr_r];
        end else begin
            id_pc   = {ADDR_W{1'b0}};
            id_inst = {INST_W{1'b0}};
        end
    end

    // Occupancy next-state: a simultaneous enq and deq leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_s, deq_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; rst and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset is applied.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_s) begin
            pc_mem_r[wr_ptr_r]   <= if_pc;
            inst_mem_r[wr_ptr_r] <= if_inst;
        end
    end

`ifdef FETCHBUF_STATS_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] flush_drop_cnt_r;
    logic [32:0] drop_sum_s;

    assign drop_sum_s     = {1'b0, flush_drop_cnt_r} + 33'(count_r);
    assign bubble_cnt     = bubble_cnt_r;
    assign flush_drop_cnt = flush_drop_cnt_r;

    // Saturating bubble and flush-discard counters, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r     <= 32'h0000_0000;
            flush_drop_cnt_r <= 32'h0000_0000;
        end else begin
            if (empty_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'h0000_0001;
            end
            if (flush) begin
                flush_drop_cnt_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buf.sv
// Self-checking bench for fetch_buf: queue-based reference model, directed plan plus random traffic.
module tb_fetch_buf;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              if_valid = 1'b0;
    logic [ADDR_W-1:0] if_pc = '0;
    logic [INST_W-1:0] if_inst = '0;
    logic              if_ready;
    logic              id_stall = 1'b0;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;
`ifdef FETCHBUF_STATS_EN
    logic [31:0]       bubble_cnt;
    logic [31:0]       flush_drop_cnt;
`endif

    always #5 clk = ~clk;

    fetch_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
`ifdef FETCHBUF_STATS_EN
        .bubble_cnt(bubble_cnt), .flush_drop_cnt(flush_drop_cnt),
`endif
        .count(count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    // Reference model: the held entries in FIFO order, plus the statistics counters.
    ent_t        model_q[$];
    longint      bubble_m = 0;
    longint      drop_m = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] next_pc = 32'h0000_1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Monitor: compares DUT outputs against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 64'(count), 64'(model_q.size()));
            check("if_ready", 64'(if_ready), 64'(model_q.size() != DEPTH));
            check("id_valid", 64'(id_valid), 64'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check("id_pc", 64'(id_pc), 64'(model_q[0].pc));
                check("id_inst", 64'(id_inst), 64'(model_q[0].inst));
            end else begin
                check("bubble_pc", 64'(id_pc), 64'd0);
                check("bubble_inst", 64'(id_inst), 64'd0);
            end
`ifdef FETCHBUF_STATS_EN
            check("bubble_cnt", 64'(bubble_cnt), 64'(sat32(bubble_m)));
            check("flush_drop_cnt", 64'(flush_drop_cnt), 64'(sat32(drop_m)));
`endif
        end
    end

    // One clock cycle of stimulus; the model advances with the same inputs at the edge.
    task automatic cycle(input bit r, input bit f, input bit v, input logic [31:0] pc,
                         input logic [31:0] inst, input bit st, output bit accepted);
        bit enq;
        bit deq;
        int sz;
        rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; id_stall = st;
        @(posedge clk);
        sz  = model_q.size();
        enq = v && (sz != DEPTH);
        deq = (sz != 0) && !st;
        accepted = 1'b0;
        if (r) begin
            bubble_m = 0;
            drop_m   = 0;
            model_q.delete();
            mon_en = 1'b1;
        end else begin
            if (sz == 0) bubble_m++;
            if (f) begin
                drop_m += sz;
                model_q.delete();
            end else begin
                if (deq) void'(model_q.pop_front());
                if (enq) begin
                    model_q.push_back('{pc: pc, inst: inst});
                    accepted = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit st);
        bit a;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, st, a);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input bit st);
        bit a;
        cycle(1'b0, 1'b0, 1'b1, pc, inst, st, a);
    endtask

    initial begin
        bit a;
        // Reset then idle.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, a);
        repeat (3) idle(1'b0);

        // Stream without stall.
        push(32'h00, 32'h11, 1'b0);
        push(32'h04, 32'h22, 1'b0);
        push(32'h08, 32'h33, 1'b0);
        repeat (2) idle(1'b0);

        // Fill under stall; IF holds a refused entry until it is accepted.
        for (int i = 0; i < 6; i++) push(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
        push(32'h110, 32'hA004, 1'b0);
        push(32'h110, 32'hA004, 1'b0);
        push(32'h114, 32'hA005, 1'b0);
        repeat (6) idle(1'b0);

        // Simultaneous enq/deq across the pointer wrap.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, a);
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 32'hB000 + 32'(i), 1'b1);
        repeat (3) idle(1'b0);
        push(32'h30C, 32'hB003, 1'b1);
        push(32'h310, 32'hB004, 1'b1);
        for (int i = 0; i < 6; i++) push(32'h314 + 32'(4 * i), 32'hB005 + 32'(i), 1'b0);
        repeat (3) idle(1'b0);

        // Flush with a concurrent enq at count 3.
        for (int i = 0; i < 3; i++) push(32'h1F0 + 32'(4 * i), 32'hC000 + 32'(i), 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h200, 32'hC0DE, 1'b0, a);
        repeat (2) idle(1'b0);

        // Reset mid-operation at count 2, then a lone entry.
        push(32'h50, 32'hD000, 1'b1);
        push(32'h54, 32'hD001, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h58, 32'hD002, 1'b0, a);
        push(32'h40, 32'hD040, 1'b0);
        repeat (2) idle(1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit f;
            bit v;
            bit st;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 5);
            v  = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 99) < 40);
            cycle(r, f, v, next_pc, $urandom, st, a);
            if (a) next_pc = next_pc + 32'h4;
        end

        idle(1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
